ro_tune_controller: RTL and testbench

//  Parametrised ring-oscillator tuning controller. Converts phase-detector up/down votes

---
 rtl/ro_tune_controller.sv | 155 +++++++++++++++
 tb/tb_ro_tune_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_tune_controller.sv
// Ring-oscillator tuning controller: vote filter, thermometer fine trim,
// coarse carry with saturation, and a reversal-based lock detector.
module ro_tune_controller #(
   parameter int THERM_W  = 16,
   parameter int COARSE_W = 2,
   parameter int FILT_TH  = 4,
   parameter int LOCK_CNT = 8
) (
   input  logic                clkUD,
   input  logic                reset,
   input  logic                up_in,
   input  logic                down_in,
   input  logic                enable,
   output logic [THERM_W-1:0]  therm_out,
   output logic [COARSE_W-1:0] coarse_sel,
   output logic                lock,
   output logic                sat_hi,
   output logic                sat_lo
);

   localparam int AW = $clog2(FILT_TH + 1) + 1;
   localparam int LW = $clog2(LOCK_CNT + 1);

   localparam logic signed [AW-1:0] ACC_HI = AW'(FILT_TH - 1);
   localparam logic signed [AW-1:0] ACC_LO = -ACC_HI;

   localparam logic [THERM_W-1:0] MID =
      {{(THERM_W/2){1'b0}}, {(THERM_W/2){1'b1}}};
   localparam logic [COARSE_W-1:0] C_RST =
      COARSE_W'(1) << (COARSE_W - 1);
   localparam logic [COARSE_W-1:0] C_MAX = '1;

   localparam logic [LW-1:0] LC_MAX = LW'(LOCK_CNT);
   localparam logic [LW-1:0] LC_M1  = LW'(LOCK_CNT - 1);

   logic [THERM_W-1:0]  therm_q,  therm_d;
   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic signed [AW-1:0] acc_q,   acc_d;
   logic [LW-1:0]       lcnt_q,   lcnt_d;
   logic                lock_q,   lock_d;
   logic                sat_hi_q, sat_hi_d;
   logic                sat_lo_q, sat_lo_d;
   logic                pv_q,     pv_d;
   logic                pdir_q,   pdir_d;

   logic vote_up, vote_dn;
   logic step_up, step_dn;
   logic full, empty;
   logic carry, borrow;

   assign vote_up = enable & up_in & ~down_in;
   assign vote_dn = enable & down_in & ~up_in;
   assign step_up = vote_up && (acc_q == ACC_HI);
   assign step_dn = vote_dn && (acc_q == ACC_LO);
   assign full    = therm_q[THERM_W-1];
   assign empty   = ~therm_q[0];
   assign carry   = step_up && full && (coarse_q != C_MAX);
   assign borrow  = step_dn && empty && (coarse_q != '0);

   always_comb begin
      acc_d = acc_q;
      if (step_up || step_dn)
         acc_d = '0;
      else if (vote_up)
         acc_d = acc_q + AW'(1);
      else if (vote_dn)
         acc_d = acc_q - AW'(1);
   end

   always_comb begin
      therm_d  = therm_q;
      coarse_d = coarse_q;
      sat_hi_d = sat_hi_q;
      sat_lo_d = sat_lo_q;
      if (step_up) begin
         sat_lo_d = 1'b0;
         if (!full) begin
            therm_d = {therm_q[THERM_W-2:0], 1'b1};
         end else if (carry) begin
            coarse_d = coarse_q + COARSE_W'(1);
            therm_d  = MID;
         end else begin
            sat_hi_d = 1'b1;
         end
      end else if (step_dn) begin
         sat_hi_d = 1'b0;
         if (!empty) begin
            therm_d = {1'b0, therm_q[THERM_W-1:1]};
         end else if (borrow) begin
            coarse_d = coarse_q - COARSE_W'(1);
            therm_d  = MID;
         end else begin
            sat_lo_d = 1'b1;
         end
      end
   end

   // Lock needs LOCK_CNT back-to-back reversals within one coarse band.
   always_comb begin
      lcnt_d = lcnt_q;
      lock_d = lock_q;
      pv_d   = pv_q;
      pdir_d = pdir_q;
      if (step_up || step_dn) begin
         if (carry || borrow) begin
            lcnt_d = '0;
            lock_d = 1'b0;
            pv_d   = 1'b0;
         end else if (!pv_q) begin
            pv_d   = 1'b1;
            pdir_d = step_up;
         end else if (step_up != pdir_q) begin
            pdir_d = step_up;
            if (lcnt_q != LC_MAX)
               lcnt_d = lcnt_q + LW'(1);
            if (lcnt_q >= LC_M1)
               lock_d = 1'b1;
         end else begin
            lcnt_d = '0;
            lock_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clkUD) begin
      if (reset) begin
         therm_q  <= MID;
         coarse_q <= C_RST;
         acc_q    <= '0;
         lcnt_q   <= '0;
         lock_q   <= 1'b0;
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
         pv_q     <= 1'b0;
         pdir_q   <= 1'b0;
      end else begin
         therm_q  <= therm_d;
         coarse_q <= coarse_d;
         acc_q    <= acc_d;
         lcnt_q   <= lcnt_d;
         lock_q   <= lock_d;
         sat_hi_q <= sat_hi_d;
         sat_lo_q <= sat_lo_d;
         pv_q     <= pv_d;
         pdir_q   <= pdir_d;
      end
   end

   assign therm_out  = therm_q;
   assign coarse_sel = coarse_q;
   assign lock       = lock_q;
   assign sat_hi     = sat_hi_q;
   assign sat_lo     = sat_lo_q;

endmodule

// File: tb/tb_ro_tune_controller.sv
// Bench for ro_tune_controller: directed scenarios plus randomized votes
// against a count-based model of the trim position and step history.
module tb_ro_tune_controller;

   localparam int THERM_W  = 16;
   localparam int COARSE_W = 2;
   localparam int FILT_TH  = 4;
   localparam int LOCK_CNT = 8;
   localparam int HALF     = THERM_W / 2;
   localparam int CMAX     = (1 << COARSE_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic up_in = 1'b0;
   logic down_in = 1'b0;
   logic enable = 1'b0;
   logic [THERM_W-1:0]  therm_out;
   logic [COARSE_W-1:0] coarse_sel;
   logic lock, sat_hi, sat_lo;

   int nchk = 0;
   int nerr = 0;

   // n = number of ones in the fine word, hist bit 0 = most recent step dir
   typedef struct {
      int          n;
      int          c;
      int          acc;
      bit          sh;
      bit          sl;
      logic [63:0] hist;
      int          hlen;
   } mdl_t;

   mdl_t m;
   bit   mvalid = 1'b0;

   always #5 clk = ~clk;

   ro_tune_controller #(
      .THERM_W (THERM_W),
      .COARSE_W(COARSE_W),
      .FILT_TH (FILT_TH),
      .LOCK_CNT(LOCK_CNT)
   ) dut (
      .clkUD     (clk),
      .reset     (reset),
      .up_in     (up_in),
      .down_in   (down_in),
      .enable    (enable),
      .therm_out (therm_out),
      .coarse_sel(coarse_sel),
      .lock      (lock),
      .sat_hi    (sat_hi),
      .sat_lo    (sat_lo)
   );

   function automatic mdl_t push(mdl_t s, bit dir);
      s.hist = {s.hist[62:0], dir};
      if (s.hlen < 64) s.hlen++;
      return s;
   endfunction

   function automatic mdl_t step(mdl_t s, bit up);
      if (up) begin
         s.sl = 1'b0;
         if (s.n < THERM_W) begin
            s.n++;
            s = push(s, 1'b1);
         end else if (s.c < CMAX) begin
            s.c++;
            s.n = HALF;
            s.hlen = 0;
         end else begin
            s.sh = 1'b1;
            s = push(s, 1'b1);
         end
      end else begin
         s.sh = 1'b0;
         if (s.n > 0) begin
            s.n--;
            s = push(s, 1'b0);
         end else if (s.c > 0) begin
            s.c--;
            s.n = HALF;
            s.hlen = 0;
         end else begin
            s.sl = 1'b1;
            s = push(s, 1'b0);
         end
      end
      return s;
   endfunction

   function automatic mdl_t nxt(mdl_t s, bit u, bit d, bit e, bit r);
      mdl_t t;
      t = s;
      if (r) begin
         t.n = HALF;
         t.c = 1 << (COARSE_W - 1);
         t.acc = 0;
         t.sh = 1'b0;
         t.sl = 1'b0;
         t.hist = '0;
         t.hlen = 0;
         return t;
      end
      if (!e || u == d) return t;
      if (u) begin
         if (s.acc == FILT_TH - 1) begin
            t.acc = 0;
            t = step(t, 1'b1);
         end else t.acc = s.acc + 1;
      end else begin
         if (s.acc == -(FILT_TH - 1)) begin
            t.acc = 0;
            t = step(t, 1'b0);
         end else t.acc = s.acc - 1;
      end
      return t;
   endfunction

   function automatic logic [THERM_W-1:0] therm_of(int n);
      logic [THERM_W-1:0] t;
      t = '0;
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      return t;
   endfunction

   // Locked when the last LOCK_CNT+1 steps strictly alternate.
   function automatic bit lock_of(mdl_t s);
      if (s.hlen < LOCK_CNT + 1) return 1'b0;
      for (int i = 0; i < LOCK_CNT; i++)
         if (s.hist[i] == s.hist[i+1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      m <= nxt(m, up_in, down_in, enable, reset);
      if (reset) mvalid <= 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("therm", 32'(therm_out), 32'(therm_of(m.n)));
         chk("coarse", 32'(coarse_sel), 32'(m.c));
         chk("lock", 32'(lock), 32'(lock_of(m)));
         chk("sat_hi", 32'(sat_hi), 32'(m.sh));
         chk("sat_lo", 32'(sat_lo), 32'(m.sl));
      end
   end

   task automatic tick(bit u, bit d, bit e, bit r);
      up_in = u;
      down_in = d;
      enable = e;
      reset = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic votes(bit u, bit d, int n);
      repeat (n) tick(u, d, 1'b1, 1'b0);
   endtask

   initial begin
      int  mode;
      bit  u, d, e, r;

      tick(0, 0, 1, 1);
      chk("rst_therm", 32'(therm_out), 32'h00FF);
      chk("rst_coarse", 32'(coarse_sel), 32'h2);
      chk("rst_lock", 32'(lock), 32'h0);
      chk("rst_sat", 32'({sat_hi, sat_lo}), 32'h0);

      votes(1, 0, 3);
      chk("up3", 32'(therm_out), 32'h00FF);
      votes(1, 0, 1);
      chk("up4", 32'(therm_out), 32'h01FF);

      tick(0, 0, 1, 1);
      for (int i = 0; i < 100; i++) begin
         tick(1, 0, 1, 0);
         tick(0, 1, 1, 0);
      end
      chk("dither_therm", 32'(therm_out), 32'h00FF);
      chk("dither_coarse", 32'(coarse_sel), 32'h2);
      votes(1, 1, 20);
      chk("both_therm", 32'(therm_out), 32'h00FF);

      tick(0, 0, 1, 1);
      votes(1, 0, 32);
      chk("full8", 32'(therm_out), 32'hFFFF);
      votes(1, 0, 4);
      chk("carry_c", 32'(coarse_sel), 32'h3);
      chk("carry_t", 32'(therm_out), 32'h00FF);
      votes(1, 0, 32);
      chk("full17", 32'(therm_out), 32'hFFFF);
      chk("nosat17", 32'(sat_hi), 32'h0);
      votes(1, 0, 4);
      chk("sat_hi18", 32'(sat_hi), 32'h1);
      chk("sat_t18", 32'(therm_out), 32'hFFFF);
      chk("sat_c18", 32'(coarse_sel), 32'h3);
      votes(0, 1, 4);
      chk("clr_hi", 32'(sat_hi), 32'h0);
      chk("dn_t", 32'(therm_out), 32'h7FFF);

      tick(0, 0, 1, 1);
      votes(0, 1, 104);
      chk("empty_t", 32'(therm_out), 32'h0000);
      chk("empty_c", 32'(coarse_sel), 32'h0);
      chk("nosat_lo", 32'(sat_lo), 32'h0);
      votes(0, 1, 4);
      chk("sat_lo", 32'(sat_lo), 32'h1);
      votes(1, 0, 4);
      chk("clr_lo", 32'(sat_lo), 32'h0);
      chk("lo_up_t", 32'(therm_out), 32'h0001);

      tick(0, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         votes(1, 0, 4);
         votes(0, 1, 4);
      end
      chk("lock8", 32'(lock), 32'h0);
      votes(1, 0, 4);
      chk("lock9", 32'(lock), 32'h1);
      votes(1, 0, 8);
      chk("unlock", 32'(lock), 32'h0);
      chk("unlock_t", 32'(therm_out), 32'h07FF);

      tick(0, 0, 1, 1);
      repeat (50) tick(1, 0, 0, 0);
      chk("frozen", 32'(therm_out), 32'h00FF);
      votes(1, 0, 10);
      chk("ramp", 32'(therm_out), 32'h03FF);
      tick(1, 0, 1, 1);
      chk("midrst_t", 32'(therm_out), 32'h00FF);
      chk("midrst_c", 32'(coarse_sel), 32'h2);
      votes(1, 0, 3);
      chk("acc_clr", 32'(therm_out), 32'h00FF);

      for (int s = 0; s < 40; s++) begin
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 150; i++) begin
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 999) == 0);
            case (mode)
               0: begin
                  u = ($urandom_range(0, 9) < 8);
                  d = !u;
               end
               1: begin
                  d = ($urandom_range(0, 9) < 8);
                  u = !d;
               end
               2: begin
                  u = ((i / FILT_TH) % 2) == 0;
                  d = !u;
                  e = 1'b1;
               end
               default: begin
                  u = 1'($urandom_range(0, 1));
                  d = 1'($urandom_range(0, 1));
               end
            endcase
            tick(u, d, e, r);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
